// File: rtl/ifid_fetch_pkg.sv
// Shared definitions for the fetch stage and IF/ID register:
// opcodes, the canonical NOP, fetch FSM encodings and the IF/ID payload.
package ifid_fetch_pkg;

  // RV32I major opcodes. Decode slices these from instr_d.
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ADDI   = 7'b0010011;
  localparam logic [6:0] OP_ADD    = 7'b0110011;

  // addi x0,x0,0: what decode sees when the IF/ID slot is empty.
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  // FETCH: nothing outstanding. WAIT: response wanted. KILL: response to drop.
  typedef enum logic [1:0] {
    FS_FETCH = 2'd0,
    FS_WAIT  = 2'd1,
    FS_KILL  = 2'd2
  } fstate_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcplus4;
  } ifid_t;

  // Instruction fetch is word aligned; low address bits are dropped.
  function automatic logic [31:0] align4(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifid_fetch_if.sv
// Instruction-memory port plus the decode-side IF/ID signals.
// master: the fetch stage. slave: memory and decode/execute.
interface ifid_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall_d;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pcplus4_d;
  logic        valid_d;

  modport master (
    output imem_req, imem_addr, instr_d, pc_d, pcplus4_d, valid_d,
    input  imem_rvalid, imem_rdata, stall_d, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_d, pc_d, pcplus4_d, valid_d,
    output imem_rvalid, imem_rdata, stall_d, redirect, redirect_pc
  );
endinterface

// File: rtl/ifid_fetch_skid_buf.sv
// One-entry skid buffer catching a fetch response that arrives while
// decode is stalled on a full IF/ID slot.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        drain_i,
  input  logic        clear_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;

  // Clear (redirect) wins over load; load and drain never coincide.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else if (drain_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/ifid_fetch.sv
// Fetch stage and IF/ID register: fetch PC, one-outstanding imem requests,
// skid buffer for decode stalls, redirect flush with response kill.
module ifid_fetch
  import ifid_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = RV_NOP
) (
  input logic          clk,
  input logic          reset,
  ifid_fetch_if.master bus
);

  fstate_e     state_q, state_d;
  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] req_pc_q, req_pc_d;
  ifid_t       ifid_q, ifid_d;
  logic        valid_d_q, valid_d_d;

  logic        fb_valid;
  logic [31:0] fb_instr;
  logic [31:0] fb_pc;

  logic        accept;
  logic        rsp_wait;
  logic        req;
  logic        fb_load;
  logic        fb_drain;

  // IF/ID can take new data when empty or when decode is moving.
  assign accept   = !valid_d_q || !bus.stall_d;
  assign rsp_wait = (state_q == FS_WAIT) && bus.imem_rvalid;
  // Back-to-back issue in WAIT only when the arriving response has a home
  // in IF/ID; while the skid buffer is full nothing new is fetched.
  assign req      = !reset && !bus.redirect && !fb_valid &&
                    ((state_q == FS_FETCH) || (rsp_wait && accept));
  assign fb_load  = !bus.redirect && rsp_wait && !accept;
  assign fb_drain = !bus.redirect && fb_valid && !bus.stall_d;

  fetch_skid_buf u_skid (
    .clk     (clk),
    .reset   (reset),
    .load_i  (fb_load),
    .drain_i (fb_drain),
    .clear_i (bus.redirect),
    .instr_i (bus.imem_rdata),
    .pc_i    (req_pc_q),
    .valid_o (fb_valid),
    .instr_o (fb_instr),
    .pc_o    (fb_pc)
  );

  // Fetch FSM next state: redirect decides whether the in-flight
  // response must be killed; otherwise track request/response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FS_FETCH: begin
        if (req) state_d = FS_WAIT;
      end
      FS_WAIT: begin
        if (bus.redirect)         state_d = bus.imem_rvalid ? FS_FETCH : FS_KILL;
        else if (req)             state_d = FS_WAIT;
        else if (bus.imem_rvalid) state_d = FS_FETCH;
      end
      FS_KILL: begin
        if (bus.imem_rvalid) state_d = FS_FETCH;
      end
      default: state_d = FS_FETCH;
    endcase
  end

  // Fetch PC and the PC of the outstanding request.
  always_comb begin
    pc_f_d   = pc_f_q;
    req_pc_d = req_pc_q;
    if (bus.redirect) begin
      pc_f_d = align4(bus.redirect_pc);
    end else if (req) begin
      pc_f_d   = pc_f_q + 32'd4;
      req_pc_d = pc_f_q;
    end
  end

  // IF/ID next value: flush, drain skid, take response, hold, or empty.
  // pc_d/pcplus4_d keep their last value when the slot empties.
  always_comb begin
    ifid_d    = ifid_q;
    valid_d_d = valid_d_q;
    if (bus.redirect) begin
      ifid_d.instr = NOP_INSTR;
      valid_d_d    = 1'b0;
    end else if (fb_valid && !bus.stall_d) begin
      ifid_d    = '{instr: fb_instr, pc: fb_pc, pcplus4: fb_pc + 32'd4};
      valid_d_d = 1'b1;
    end else if (rsp_wait && accept) begin
      ifid_d    = '{instr: bus.imem_rdata, pc: req_pc_q, pcplus4: req_pc_q + 32'd4};
      valid_d_d = 1'b1;
    end else if (valid_d_q && bus.stall_d) begin
      valid_d_d = 1'b1;
    end else begin
      ifid_d.instr = NOP_INSTR;
      valid_d_d    = 1'b0;
    end
  end

  // State, PC and IF/ID registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FS_FETCH;
      pc_f_q    <= RESET_PC;
      req_pc_q  <= RESET_PC;
      ifid_q    <= '{instr: NOP_INSTR, pc: 32'h0, pcplus4: 32'h4};
      valid_d_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_f_q    <= pc_f_d;
      req_pc_q  <= req_pc_d;
      ifid_q    <= ifid_d;
      valid_d_q <= valid_d_d;
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc_f_q;
  assign bus.instr_d   = ifid_q.instr;
  assign bus.pc_d      = ifid_q.pc;
  assign bus.pcplus4_d = ifid_q.pcplus4;
  assign bus.valid_d   = valid_d_q;

endmodule
